// File: rtl/pl_stage_sequencer_if.sv
// Control/status bundle between the polynomial pipeline parent and its stage sequencer.
// Port suffixes are from the sequencer's point of view.
interface pl_stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TO_W       = 16
);
  logic                  en_i;
  logic                  start_i;
  logic [NUM_STAGES-1:0] skip_mask_i;
  logic [TO_W-1:0]       timeout_cycles_i;
  logic [NUM_STAGES-1:0] stage_start_o;
  logic [NUM_STAGES-1:0] stage_done_i;
  logic [SEL_W-1:0]      cur_stage_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  modport slave (
    input  en_i, start_i, skip_mask_i, timeout_cycles_i, stage_done_i,
    output stage_start_o, cur_stage_o, busy_o, done_o, error_o
  );

  modport master (
    output en_i, start_i, skip_mask_i, timeout_cycles_i, stage_done_i,
    input  stage_start_o, cur_stage_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/pl_stage_sequencer.sv
// Launches the NewHope pipeline stages in ascending order, one at a time, with skip mask,
// per-stage watchdog and sticky error; cur_stage steers the shared poly RAM mux.
module pl_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TO_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  pl_stage_sequencer_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StGap, StFinish, StError} state_e;

  state_e                state_q;
  logic [NUM_STAGES-1:0] skip_q;
  logic [NUM_STAGES-1:0] stage_start_q;
  logic [SEL_W-1:0]      cur_stage_q;
  logic [TO_W-1:0]       wd_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  first_found;
  logic [SEL_W-1:0]      first_idx;
  logic                  next_found;
  logic [SEL_W-1:0]      next_idx;
  logic [NUM_STAGES-1:0] cur_onehot;
  logic                  own_done;
  logic                  other_done;
  logic                  timeout_hit;

  // Descending scans so the lowest qualifying index is the last one written.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus_io.skip_mask_i[i]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
      if (!skip_q[i] && (SEL_W'(i) > cur_stage_q)) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    cur_onehot  = NUM_STAGES'(1) << cur_stage_q;
    own_done    = |(bus_io.stage_done_i & cur_onehot);
    other_done  = |(bus_io.stage_done_i & ~cur_onehot);
    timeout_hit = (bus_io.timeout_cycles_i != '0) &&
                  (wd_q == (bus_io.timeout_cycles_i - 1'b1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      skip_q        <= '0;
      stage_start_q <= '0;
      cur_stage_q   <= '0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else if (bus_io.en_i) begin
      case (state_q)
        StIdle: begin
          if (bus_io.start_i) begin
            skip_q  <= bus_io.skip_mask_i;
            error_q <= 1'b0;
            if (first_found) begin
              cur_stage_q   <= first_idx;
              stage_start_q <= NUM_STAGES'(1) << first_idx;
              busy_q        <= 1'b1;
              state_q       <= StLaunch;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFinish;
            end
          end
        end
        StLaunch: begin
          stage_start_q <= '0;
          wd_q          <= '0;
          state_q       <= StWait;
        end
        StWait: begin
          // A foreign done outranks our own; our own done outranks the watchdog.
          if (other_done || (!own_done && timeout_hit)) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StError;
          end else if (own_done) begin
            state_q <= StGap;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StGap: begin
          if (next_found) begin
            cur_stage_q   <= next_idx;
            stage_start_q <= NUM_STAGES'(1) << next_idx;
            state_q       <= StLaunch;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        StError: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pulses are held while frozen and only become visible in the first enabled cycle.
  assign bus_io.stage_start_o = bus_io.en_i ? stage_start_q : '0;
  assign bus_io.done_o        = done_q & bus_io.en_i;
  assign bus_io.cur_stage_o   = cur_stage_q;
  assign bus_io.busy_o        = busy_q;
  assign bus_io.error_o       = error_q;

endmodule
